// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the three requester ports and the RAM side of the
// arbiter into one interface.
//
// Handshake, identical on the CPU, D1 and D2 ports:
//   * <P>_req is a level. While it is high, <P>_wr/<P>_addr/<P>_wdata must hold
//     steady until <P>_ack.
//   * <P>_ack is a one-cycle pulse two cycles after the port wins arbitration.
//     <P>_rdata is valid with it: RAM data for a read, 0 for a write, and 0
//     whenever ack is low.
//   * A req still high in the cycle after ack is taken as a new request.
//   * CPU_lock is sampled with the CPU request. When set, it keeps D1 and D2
//     off the RAM until an unlocked CPU access or the lock timeout.
//
// RAM side: RAM_addr/RAM_out/RAM_wr are registered. RAM_data is expected one
// cycle after the address. GRANT names the owner of the current RAM cycle.
//
// Modports:
//   slave  - the arbiter
//   master - the requesters plus the RAM (testbench side)
interface ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          CPU_req;
  logic          CPU_wr;
  logic          CPU_lock;
  logic [AW-1:0] CPU_addr;
  logic [DW-1:0] CPU_wdata;
  logic          CPU_ack;
  logic [DW-1:0] CPU_rdata;

  logic          D1_req;
  logic          D1_wr;
  logic [AW-1:0] D1_addr;
  logic [DW-1:0] D1_wdata;
  logic          D1_ack;
  logic [DW-1:0] D1_rdata;

  logic          D2_req;
  logic          D2_wr;
  logic [AW-1:0] D2_addr;
  logic [DW-1:0] D2_wdata;
  logic          D2_ack;
  logic [DW-1:0] D2_rdata;

  logic [AW-1:0] RAM_addr;
  logic [DW-1:0] RAM_out;
  logic          RAM_wr;
  logic [DW-1:0] RAM_data;
  logic [1:0]    GRANT;

  modport slave (
    input  CPU_req, CPU_wr, CPU_lock, CPU_addr, CPU_wdata,
    output CPU_ack, CPU_rdata,
    input  D1_req, D1_wr, D1_addr, D1_wdata,
    output D1_ack, D1_rdata,
    input  D2_req, D2_wr, D2_addr, D2_wdata,
    output D2_ack, D2_rdata,
    output RAM_addr, RAM_out, RAM_wr, GRANT,
    input  RAM_data
  );

  modport master (
    output CPU_req, CPU_wr, CPU_lock, CPU_addr, CPU_wdata,
    input  CPU_ack, CPU_rdata,
    output D1_req, D1_wr, D1_addr, D1_wdata,
    input  D1_ack, D1_rdata,
    output D2_req, D2_wr, D2_addr, D2_wdata,
    input  D2_ack, D2_rdata,
    input  RAM_addr, RAM_out, RAM_wr, GRANT,
    output RAM_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous-read RAM between the CPU and two device
// masters (D1 display fetch, D2 DMA). At most one access is issued per cycle.
// The CPU has fixed priority, and D1/D2 alternate round-robin. A CPU lock
// excludes the devices across a read-modify-write. The lock is released
// automatically after LOCK_MAX idle locked cycles.
//
// Pipeline for a port that wins in cycle N:
//   N+1 : RAM_addr/RAM_out/RAM_wr carry the access, and GRANT = port id
//   N+2 : the port's ack pulses, and rdata = RAM_data (reads) or 0 (writes)
//
// Ports:
//   CORE_CLK - clock, rising edge
//   RESET_N  - asynchronous active-low reset
//   bus      - ram_arbiter_if.slave (requester handshakes, RAM side, GRANT)
module ram_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic            CORE_CLK,
  input  logic            RESET_N,
  ram_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_D1   = 2'd2,
    OWN_D2   = 2'd3
  } owner_t;

  localparam logic [7:0] LOCK_CNT_LAST = 8'(LOCK_MAX - 1);

  owner_t        win;          // combinational winner of this cycle
  owner_t        stage1_q;     // owner of the RAM cycle (N+1), drives GRANT
  owner_t        stage2_q;     // owner of the ack cycle (N+2)
  logic          stage2_wr_q;  // ack-cycle access was a write -> rdata 0
  logic          lock_q;
  logic [7:0]    lock_cnt_q;
  logic          rr_d2_q;      // 1: D2 wins a D1/D2 tie, 0: D1 wins
  logic          cpu_elig, d1_elig, d2_elig;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_wr;

  // A port is eligible only when it has no access in stage N+1 or N+2.
  // As a result, each port can win at most once every three cycles.
  always_comb begin
    cpu_elig = bus.CPU_req && (stage1_q != OWN_CPU) && (stage2_q != OWN_CPU);
    d1_elig  = bus.D1_req  && (stage1_q != OWN_D1)  && (stage2_q != OWN_D1);
    d2_elig  = bus.D2_req  && (stage1_q != OWN_D2)  && (stage2_q != OWN_D2);

    win = OWN_NONE;
    if (cpu_elig) begin
      win = OWN_CPU;
    end else if (!lock_q) begin
      if (d1_elig && d2_elig) win = rr_d2_q ? OWN_D2 : OWN_D1;
      else if (d1_elig)       win = OWN_D1;
      else if (d2_elig)       win = OWN_D2;
    end
  end

  always_comb begin
    sel_addr  = bus.CPU_addr;
    sel_wdata = bus.CPU_wdata;
    sel_wr    = 1'b0;
    case (win)
      OWN_CPU: begin
        sel_addr  = bus.CPU_addr;
        sel_wdata = bus.CPU_wdata;
        sel_wr    = bus.CPU_wr;
      end
      OWN_D1: begin
        sel_addr  = bus.D1_addr;
        sel_wdata = bus.D1_wdata;
        sel_wr    = bus.D1_wr;
      end
      OWN_D2: begin
        sel_addr  = bus.D2_addr;
        sel_wdata = bus.D2_wdata;
        sel_wr    = bus.D2_wr;
      end
      default: ;
    endcase
  end

  // RAM request register and the two pipeline stages. On idle cycles the
  // address and write data keep their previous values, and only the write
  // enable is forced low.
  always_ff @(posedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stage1_q     <= OWN_NONE;
      stage2_q     <= OWN_NONE;
      stage2_wr_q  <= 1'b0;
      bus.RAM_addr <= '0;
      bus.RAM_out  <= '0;
      bus.RAM_wr   <= 1'b0;
    end else begin
      stage1_q    <= win;
      stage2_q    <= stage1_q;
      stage2_wr_q <= bus.RAM_wr;
      bus.RAM_wr  <= sel_wr;
      if (win != OWN_NONE) begin
        bus.RAM_addr <= sel_addr;
        bus.RAM_out  <= sel_wdata;
      end
    end
  end

  // Lock and round-robin state. Every CPU grant reloads the lock from
  // CPU_lock. While the lock is set, each cycle without a CPU grant counts
  // toward the forced release.
  always_ff @(posedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
      rr_d2_q    <= 1'b0;
    end else begin
      if (win == OWN_CPU) begin
        lock_q     <= bus.CPU_lock;
        lock_cnt_q <= '0;
      end else if (lock_q) begin
        if (lock_cnt_q == LOCK_CNT_LAST) begin
          lock_q     <= 1'b0;
          lock_cnt_q <= '0;
        end else begin
          lock_cnt_q <= lock_cnt_q + 8'd1;
        end
      end
      if (win == OWN_D1)      rr_d2_q <= 1'b1;
      else if (win == OWN_D2) rr_d2_q <= 1'b0;
    end
  end

  assign bus.GRANT = stage1_q;

  assign bus.CPU_ack = (stage2_q == OWN_CPU);
  assign bus.D1_ack  = (stage2_q == OWN_D1);
  assign bus.D2_ack  = (stage2_q == OWN_D2);

  assign bus.CPU_rdata = (bus.CPU_ack && !stage2_wr_q) ? bus.RAM_data : '0;
  assign bus.D1_rdata  = (bus.D1_ack  && !stage2_wr_q) ? bus.RAM_data : '0;
  assign bus.D2_rdata  = (bus.D2_ack  && !stage2_wr_q) ? bus.RAM_data : '0;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single synchronous-read RAM between the CPU and two device masters: D1 (display fetch) and D2 (device DMA).
- Per-port request/acknowledge handshake; at most one RAM access issued per cycle.
- The CPU has fixed priority. D1 and D2 round-robin between themselves.
- A CPU lock keeps a read-modify-write sequence atomic against the devices.

Parameters:
AW, 16, address width
DW, 16, data width
LOCK_MAX, 8, idle cycles after which a held CPU lock is forcibly released (1..255)

Ports:
CORE_CLK  in  1  clock; all state updates on rising edge
RESET_N  in  1  asynchronous active-low reset
CPU_req  in  1  CPU access request (level)
CPU_wr  in  1  1=write, 0=read
CPU_lock  in  1  keep devices excluded after this access
CPU_addr  in  AW  address
CPU_wdata  in  DW  write data
CPU_ack  out  1  one-cycle completion pulse
CPU_rdata  out  DW  read data, valid with CPU_ack
D1_req, D1_wr, D1_addr, D1_wdata  in  1,1,AW,DW  as CPU, no lock
D1_ack, D1_rdata  out  1,DW  as CPU
D2_req, D2_wr, D2_addr, D2_wdata  in  1,1,AW,DW  as CPU, no lock
D2_ack, D2_rdata  out  1,DW  as CPU
RAM_addr  out  AW  registered RAM address
RAM_out  out  DW  registered RAM write data
RAM_wr  out  1  registered RAM write enable
RAM_data  in  DW  RAM read data, valid one cycle after address
GRANT  out  2  owner of the current RAM cycle: 0 none, 1 CPU, 2 D1, 3 D2

Behaviour:
- Reset (async, RESET_N low):
  - RAM_addr, RAM_out, RAM_wr, all acks, all rdata and GRANT go to 0.
  - Lock flag and lock counter cleared; round-robin pointer favours D1.
  - Any in-flight access is dropped and never acked. RAM_wr drops immediately.
- Pipeline for a port that wins arbitration in cycle N:
  - N+1: RAM_addr/RAM_out/RAM_wr hold its request and GRANT = port id. Write data is committed by RAM at the end of N+1.
  - N+2: its ack is high for exactly one cycle. rdata = RAM_data for reads; 0 for writes.
  - rdata is 0 whenever ack is low.
- Idle cycles: RAM_wr=0 and GRANT=0. RAM_addr and RAM_out hold their last values.
- Eligibility:
  - A port is eligible in a cycle if req=1 and the port is in neither stage N+1 nor N+2.
  - So a given port can win at most once every 3 cycles.
  - A req sampled in the cycle after ack is a new request. Requesters hold addr/wr/wdata stable from req rise until ack, then either drop req or present the next request.
- Arbitration (combinational; winner registered each cycle):
  - Priority: CPU > device.
  - Between devices, the one not granted last wins (round-robin pointer); the pointer updates only on device grants.
  - While the lock flag is set, D1/D2 are never granted.
- Lock:
  - Set at the CPU grant edge when CPU_lock=1.
  - Cleared at the CPU grant edge when CPU_lock=0; a device may win from the following cycle.
  - Lock counter:
    - counts cycles with the lock flag set and no CPU grant;
    - resets to 0 on every CPU grant;
    - on reaching LOCK_MAX, it clears the flag and resets to 0.
- Simultaneous events:
  - A device request in the cycle the lock is set is not granted.
  - Both devices eligible with the lock flag clear and the CPU idle: the round-robin winner is granted; the loser gets the next eligible cycle.
- Requests that drop before being granted are forgotten silently. An access that has been granted always completes and is acked.

Test Plan:
1. RAM[0x0040]=0xBEEF; CPU_req rises cycle 0 with addr 0x0040, wr=0 -> cycle 1: RAM_addr=0x0040, RAM_wr=0, GRANT=1; cycle 2: CPU_ack=1, CPU_rdata=0xBEEF; rdata=0 in all other cycles.
2. D2 writes 0x1234 to 0x0200 (cycle 0), then drops req and reads 0x0200 starting in the cycle after D2_ack -> cycle 1: RAM_wr=1, RAM_out=0x1234; D2_rdata=0x1234 on the read's ack.
3. CPU, D1 and D2 req held high from cycle 0, new addresses each time -> grants CPU,D1,D2,CPU,D1,D2 at cycles 0..5; acks at cycles 2,3,4,5,6,7; RAM_wr never set for idle cycles.
4. Lock sequence:
   - CPU read 0x0100 with lock=1 at cycle 0; D1_req held from cycle 1; CPU write 0x0100 with lock=0 requested cycle 3.
   - Required: D1 not granted in cycles 1-3; D1 granted cycle 4; D1_ack cycle 6.
5. Lock timeout (LOCK_MAX=8):
   - CPU locked read granted cycle 0, then no CPU req; D2_req held.
   - Required: lock released end of cycle 8; D2 granted cycle 9; D2_ack cycle 11.
6. Reset mid-operation:
   - Assert RESET_N=0 in the N+1 cycle of a D1 write.
   - Required: RAM_wr=0 immediately; D1_ack never pulses.
   - Required after release: with D1 and D2 requesting, D1 wins first (round-robin pointer reset).
